// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA bus arbiter: ownership states and
// the width of the channel index.
package dma_pkg;

    localparam int DMA_MAX_REQ = 8;
    localparam int OWNER_W     = 3;

    typedef enum logic [1:0] {
        CPU_OWN,
        DRAIN_CPU,
        DMA_OWN,
        DRAIN_DMA
    } arb_state_e;

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin select: first requesting channel at or after ptr,
// wrapping at NUM_REQ, returned both one-hot and as an index.
module dma_rr_picker
    import dma_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               any_req
);

    logic               found;
    logic [NUM_REQ-1:0] cand_oh;
    int                 cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand_oh      = '0;
        cand         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand    = (int'(ptr) + i) % NUM_REQ;
            cand_oh = NUM_REQ'(1) << cand;
            if (!found && |(req & cand_oh)) begin
                found        = 1'b1;
                grant_idx    = OWNER_W'(cand);
                grant_onehot = cand_oh;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shared-bus arbiter between the CPU (default owner) and NUM_REQ DMA channels.
// Define ARB_HOLD_LIMIT_EN to let the CPU reclaim the bus after MAX_HOLD cycles.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic [NUM_REQ-1:0] bus_req,
    input  logic               frame_n,
    output logic               cpu_grant,
    output logic [NUM_REQ-1:0] bus_grant,
    output logic [OWNER_W-1:0] owner_id,
    output logic               hold_timeout
);

    if (NUM_REQ < 1 || NUM_REQ > DMA_MAX_REQ) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end
    if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
        $error("CNT_W too narrow for MAX_HOLD");
    end

    arb_state_e         state_q, state_d;
    logic               cpu_grant_q, cpu_grant_d;
    logic [NUM_REQ-1:0] bus_grant_q, bus_grant_d;
    logic [OWNER_W-1:0] owner_id_q, owner_id_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               revoke;
    logic [OWNER_W-1:0] next_ptr;

    dma_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req          (bus_req),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any_req      (pick_any)
    );

    // While a channel owns the bus its grant is the one-hot of owner_id.
    assign owner_req = |(bus_req & bus_grant_q);
    assign next_ptr  = (owner_id_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_id_q + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_timeout_q, hold_timeout_d;

    assign revoke       = (state_q == DMA_OWN) && (hold_cnt_q == CNT_W'(MAX_HOLD)) && cpu_req;
    assign hold_timeout = hold_timeout_q;

    always_comb begin
        hold_cnt_d     = hold_cnt_q;
        hold_timeout_d = revoke;
        if (state_q == DRAIN_CPU && frame_n && pick_any) begin
            hold_cnt_d = '0;
        end else if (state_q == DMA_OWN && hold_cnt_q != CNT_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end
`else
    assign revoke       = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cpu_grant_d = cpu_grant_q;
        bus_grant_d = bus_grant_q;
        owner_id_d  = owner_id_q;
        rr_ptr_d    = rr_ptr_q;
        unique case (state_q)
            CPU_OWN: begin
                if (pick_any && !cpu_req) begin
                    state_d     = DRAIN_CPU;
                    cpu_grant_d = 1'b0;
                end
            end
            DRAIN_CPU: begin
                if (frame_n) begin
                    if (pick_any) begin
                        state_d     = DMA_OWN;
                        bus_grant_d = pick_onehot;
                        owner_id_d  = pick_idx;
                    end else begin
                        state_d     = CPU_OWN;
                        cpu_grant_d = 1'b1;
                    end
                end
            end
            DMA_OWN: begin
                // Advancing the pointer past the owner puts it last in line,
                // which is also where a revoked channel belongs.
                if (revoke || !owner_req) begin
                    state_d     = DRAIN_DMA;
                    bus_grant_d = '0;
                    rr_ptr_d    = next_ptr;
                end
            end
            DRAIN_DMA: begin
                if (frame_n) begin
                    if (pick_any && !cpu_req) begin
                        state_d = DRAIN_CPU;
                    end else begin
                        state_d     = CPU_OWN;
                        cpu_grant_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = CPU_OWN;
                cpu_grant_d = 1'b1;
                bus_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CPU_OWN;
            cpu_grant_q <= 1'b1;
            bus_grant_q <= '0;
            owner_id_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cpu_grant_q <= cpu_grant_d;
            bus_grant_q <= bus_grant_d;
            owner_id_q  <= owner_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cpu_grant = cpu_grant_q;
    assign bus_grant = bus_grant_q;
    assign owner_id  = owner_id_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a bus-ownership model.
module tb_dma_bus_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam int CPU    = -1;
    localparam int PARKED = -2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cpu_req = 1'b0;
    logic [NUM_REQ-1:0] bus_req = '1;
    logic               frame_n = 1'b1;
    logic               cpu_grant;
    logic [NUM_REQ-1:0] bus_grant;
    logic [2:0]         owner_id;
    logic               hold_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    dma_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .bus_req      (bus_req),
        .frame_n      (frame_n),
        .cpu_grant    (cpu_grant),
        .bus_grant    (bus_grant),
        .owner_id     (owner_id),
        .hold_timeout (hold_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who holds the bus: CPU, nobody (handover in progress) or a channel index.
    int m_owner     = CPU;
    int m_last      = 0;
    int m_ptr       = 0;
    int m_hold      = 0;
    bit m_returning = 1'b0;
    bit m_timeout   = 1'b0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            int c = (ptr + i) % NUM_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        bit revoke;
        bit still_req;
        m_timeout = 1'b0;
        if (m_owner == CPU) begin
            if (bus_req != 0 && !cpu_req) begin
                m_owner     = PARKED;
                m_returning = 1'b0;
            end
        end else if (m_owner == PARKED) begin
            if (frame_n) begin
                if (m_returning) begin
                    m_returning = 1'b0;
                    if (bus_req == 0 || cpu_req) m_owner = CPU;
                end else begin
                    w = rr_pick(bus_req, m_ptr);
                    if (w < 0) begin
                        m_owner = CPU;
                    end else begin
                        m_owner = w;
                        m_last  = w;
                        m_hold  = 0;
                    end
                end
            end
        end else begin
            still_req = ((bus_req >> m_owner) & 1) != 0;
            revoke    = HOLD_EN && (m_hold == MAX_HOLD) && cpu_req;
            if (revoke || !still_req) begin
                m_timeout   = revoke;
                m_ptr       = (m_owner + 1) % NUM_REQ;
                m_owner     = PARKED;
                m_returning = 1'b1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner     = CPU;
            m_last      = 0;
            m_ptr       = 0;
            m_hold      = 0;
            m_returning = 1'b0;
            m_timeout   = 1'b0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        logic [31:0] exp_bg;
        @(negedge clk);
        exp_bg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("model_cpu_grant", 32'(cpu_grant), 32'(m_owner == CPU));
        check("model_bus_grant", 32'(bus_grant), exp_bg);
        check("model_owner_id", 32'(owner_id), 32'(m_last));
        check("model_hold_timeout", 32'(hold_timeout), 32'(m_timeout));
        check("grant_exclusive", 32'(cpu_grant && (bus_grant != 0)), 32'd0);
        check("grant_onehot", 32'($countones(bus_grant) <= 1), 32'd1);
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        frame_n = 1'b1;
        bus_req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input int limit, input string name);
        bit ok;
        ok = (bus_grant != 0);
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (bus_grant != 0);
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int cnt;
        bit seen_to;

        // Reset with both channels requesting
        repeat (3) @(negedge clk);
        check("rst_cpu_grant", 32'(cpu_grant), 32'd1);
        check("rst_bus_grant", 32'(bus_grant), 32'd0);
        check("rst_owner_id", 32'(owner_id), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("release_grant_ch0", 32'(bus_grant), 32'b01);

        // Round-robin alternation
        for (int k = 0; k < 4; k++) begin
            wait_grant(20, "rr_wait");
            check("rr_owner", 32'(owner_id), 32'(k % 2));
            check("rr_grant", 32'(bus_grant), 32'd1 << (k % 2));
            repeat (4) @(negedge clk);
            bus_req[owner_id[0]] = 1'b0;
            @(negedge clk);
            bus_req = 2'b11;
        end

        // Quiet-bus rule
        do_reset();
        frame_n = 1'b0;
        bus_req = 2'b10;
        @(negedge clk);
        check("quiet_cpu_drop", 32'(cpu_grant), 32'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("quiet_no_grant", 32'(bus_grant), 32'd0);
        end
        frame_n = 1'b1;
        @(negedge clk);
        check("quiet_grant_ch1", 32'(bus_grant), 32'b10);
        check("quiet_owner", 32'(owner_id), 32'd1);

        // CPU wins a simultaneous request
        do_reset();
        cpu_req = 1'b1;
        bus_req = 2'b01;
        repeat (3) @(negedge clk);
        check("cpu_prio_cpu", 32'(cpu_grant), 32'd1);
        check("cpu_prio_bus", 32'(bus_grant), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("cpu_fall_grant", 32'(bus_grant), 32'b01);

        // Hold limit
        do_reset();
        bus_req = 2'b01;
        repeat (2) @(negedge clk);
        check("hold_grant_ch0", 32'(bus_grant), 32'b01);
        cnt     = 0;
        seen_to = 1'b0;
        while (cnt < 40 && !seen_to) begin
            @(negedge clk);
            cnt++;
            if (cnt == 5) cpu_req = 1'b1;
            seen_to = hold_timeout;
        end
        if (HOLD_EN) begin
            check("hold_timeout_seen", 32'(seen_to), 32'd1);
            check("hold_timeout_cycle", 32'(cnt), 32'd17);
            check("hold_revoked", 32'(bus_grant), 32'd0);
            @(negedge clk);
            check("hold_cpu_back", 32'(cpu_grant), 32'd1);
            check("hold_pulse_1cyc", 32'(hold_timeout), 32'd0);
        end else begin
            check("nohold_no_timeout", 32'(seen_to), 32'd0);
            check("nohold_kept", 32'(bus_grant), 32'b01);
        end
        cpu_req = 1'b0;

        // Async reset while ch1 owns the bus
        do_reset();
        bus_req = 2'b01;
        repeat (2) @(negedge clk);
        bus_req = 2'b10;
        @(negedge clk);
        wait_grant(10, "async_wait_ch1");
        check("async_pre_grant", 32'(bus_grant), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async_bus_drop", 32'(bus_grant), 32'd0);
        check("async_cpu_grant", 32'(cpu_grant), 32'd1);
        @(negedge clk);
        bus_req = 2'b11;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check("async_ptr_reset", 32'(bus_grant), 32'b01);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            cpu_req = ($urandom_range(3) == 0);
            frame_n = ($urandom_range(4) != 0);
            for (int c = 0; c < NUM_REQ; c++) begin
                if ($urandom_range(23) == 0) bus_req[c] = ~bus_req[c];
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Decides who drives the shared memory bus (Address/Data/read/write/Frame): the CPU, which owns the bus by default, or one of NUM_REQ DMA channels.
- Turns each channel's BusRequest into a clean grant handshake. Handover happens only while the bus is quiet.
- Round-robin between channels; CPU may reclaim the bus after a hold limit.
- Sits between the DMA channel instances and the CPU bus interface.

Parameters:
- NUM_REQ, 2: number of DMA channel requesters (1..8).
- MAX_HOLD, 16: cycles a channel may hold the bus before the CPU may reclaim it.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU needs the bus.
- bus_req  in  NUM_REQ  per-channel BusRequest, level; held until the channel's transfer is done.
- frame_n  in  1  active-low Frame; 0 means a transfer is in progress on the bus.
- cpu_grant  out  1  CPU owns the bus.
- bus_grant  out  NUM_REQ  one-hot channel grant.
- owner_id  out  3  index of the last/current granted channel.
- hold_timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Single clock domain, all outputs registered.
- Async reset values: state=CPU_OWN, cpu_grant=1, bus_grant=0, owner_id=0, hold_timeout=0, rr_ptr=0, hold_cnt=0.
- Invariant: cpu_grant and bus_grant are never both nonzero; bus_grant is always one-hot or zero.
- States: CPU_OWN, DRAIN_CPU, DMA_OWN, DRAIN_DMA.
- CPU_OWN:
  - Exit when any bus_req bit is set and cpu_req=0 -> DRAIN_CPU.
  - cpu_req=1 blocks handover; the CPU keeps the bus.
- DRAIN_CPU:
  - cpu_grant=0.
  - Wait until frame_n=1 is sampled. Then select a winner by round-robin starting at rr_ptr, set bus_grant[winner] and owner_id=winner -> DMA_OWN.
  - Minimum bus_req-to-grant latency is 2 cycles.
  - If all bus_req have dropped by then -> CPU_OWN; cpu_grant reasserts the next cycle.
- DMA_OWN:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Normal release: bus_req[owner_id]=0 -> DRAIN_DMA.
- DRAIN_DMA:
  - bus_grant=0; wait until frame_n=1.
  - rr_ptr=owner_id+1, wrapping NUM_REQ-1 -> 0.
  - If another bus_req is pending and cpu_req=0 -> DRAIN_CPU path: re-arbitrate next cycle, cpu_grant stays 0. Otherwise -> CPU_OWN.
- Bus quiet rule: a grant is never issued while frame_n=0. A stuck frame_n=0 holds the arbiter in a DRAIN state indefinitely.
- Same-cycle events: a new bus_req arriving in the same cycle as a release is seen at the next arbitration. cpu_req and bus_req asserted together in CPU_OWN: the CPU wins.
- Reset mid-transfer: grants drop immediately (async); the CPU owns the bus after release.
- hold_cnt clears on every new grant.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined: in DMA_OWN, if hold_cnt==MAX_HOLD and cpu_req=1:
  - revoke the grant -> DRAIN_DMA;
  - hold_timeout pulses 1 cycle;
  - the revoked channel keeps bus_req high and is re-arbitrated later at lowest round-robin priority.
- Undefined: no preemption, hold_timeout tied 0, hold_cnt logic removed. A channel keeps the bus until it drops bus_req.

Decomposition:
- Package dma_pkg holds:
  - the state enum (CPU_OWN, DRAIN_CPU, DMA_OWN, DRAIN_DMA);
  - DMA_MAX_REQ=8;
  - the owner_id width constant (3).
- One sub-module, dma_rr_picker: combinational round-robin one-hot select from (req vector, rr_ptr), outputting grant_onehot, grant_idx and any_req.

Test Plan:
- Reset:
  - rst_n=0 with bus_req=2'b11 -> cpu_grant=1, bus_grant=0.
  - Release with frame_n=1, cpu_req=0 -> bus_grant=2'b01 by the 3rd cycle after release.
- Round-robin: bus_req=2'b11 held, each channel drops its request 4 cycles after its grant and reasserts it 1 cycle later -> grant order ch0, ch1, ch0, ch1, owner_id alternating 0/1.
- Quiet-bus rule: bus_req[1]=1 while frame_n=0 for 10 cycles -> cpu_grant=0 after 1 cycle, bus_grant stays 0 until 1 cycle after frame_n=1.
- CPU priority: cpu_req=1 and bus_req[0]=1 in the same cycle from CPU_OWN -> cpu_grant stays 1. When cpu_req falls -> grant ch0 within 2 cycles.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=16): ch0 granted, cpu_req=1 at cycle 5 -> hold_timeout pulses when hold_cnt=16, bus_grant=0 the same cycle, cpu_grant=1 once frame_n=1. Without the macro: ch0 is never revoked.
- Async reset mid-grant: rst_n low while bus_grant=2'b10 -> bus_grant=0 and cpu_grant=1 without waiting for a clock edge; rr_ptr=0 after release.
